// File: rtl/decoder_2to4_pulse_pkg.sv
// Shared types and helpers for the 2-to-4 pulse decoder: FSM states, code widths, one-hot mapping.
package decoder_pkg;

  localparam int CODE_W     = 2;
  localparam int ONEHOT_W   = 4;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decoder_2to4_pulse_hold_counter.sv
// Loadable down-counter with zero flag that times the strobe; load wins over decrement.
// One-cycle update; decrement stops at zero rather than wrapping.
module pulse_hold_counter
  import decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [HOLD_CNT_W-1:0] load_value,
  input  logic                  dec,
  output logic                  zero
);

  logic [HOLD_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Decodes a handshaked 2-bit code into a one-hot strobe held HOLD_CYCLES cycles plus a 1-cycle gap.
// Strobe appears right after the accepting edge; in_ready is low for HOLD_CYCLES+1 cycles after each accept.
module decoder_2to4_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   in_code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    event_count
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end

  // Counter is loaded with HOLD_CYCLES-1 so the terminal zero lands on the last strobe cycle.
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

  state_t state;
  logic   accept;
  logic   hold_zero;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  pulse_hold_counter u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (HOLD_LOAD),
    .dec        (state == ST_HOLD),
    .zero       (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out         <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      event_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_HOLD;
            out       <= onehot_of(in_code);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            if (event_count != '1) begin
              event_count <= event_count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_zero) begin
            state     <= ST_GAP;
            out       <= '0;
            out_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// Scoreboard bench: timing model pushes expected strobes at each handshake; a negedge monitor pops and compares.
module tb_decoder_2to4_pulse;

  localparam int H0 = 4;
  localparam int W0 = 8;
  localparam int H1 = 1;
  localparam int W1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'd0;
  logic       in_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       busy;
  logic [W0-1:0] event_count;

  logic       v1 = 1'b0;
  logic [1:0] c1 = 2'd0;
  logic       rdy1;
  logic [3:0] o1;
  logic       ov1;
  logic       b1;
  logic [W1-1:0] ec1;

  always #5 clk = ~clk;

  decoder_2to4_pulse #(.HOLD_CYCLES(H0), .CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .busy(busy), .event_count(event_count)
  );

  decoder_2to4_pulse #(.HOLD_CYCLES(H1), .CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .in_ready(rdy1),
    .out(o1), .out_valid(ov1), .busy(b1), .event_count(ec1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] oh;
    int         start;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  int   cyc       = 0;
  int   next_free = 0;
  int   last_n    = 0;
  bit   has_hs    = 0;
  int   cnt_m     = 0;
  int   hs_total  = 0;
  bit   abort_len = 0;

  // Reference timing: a handshake at edge N owns edges N..N+H0 (strobe then gap), ready again from N+H0+1.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      cnt_m     = 0;
      has_hs    = 0;
      next_free = cyc;
      abort_len = 1;
      sbq.delete();
    end else if (in_valid && ((cyc - 1) >= next_free)) begin
      last_n    = cyc;
      has_hs    = 1;
      next_free = cyc + H0 + 1;
      if (cnt_m < (2 ** W0) - 1) cnt_m = cnt_m + 1;
      hs_total  = hs_total + 1;
      sbq.push_back('{oh: 4'b0001 << in_code, start: cyc, cnt: cnt_m});
    end
  end

  bit prev_vld = 0;
  int len      = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("in_ready", in_ready, (!rst && cyc >= next_free));
      check("busy", busy, (has_hs && cyc <= last_n + H0));
      check("out_valid_vs_out", out_valid, (out != 4'b0000));
      check("event_count", event_count, cnt_m);
      if (out_valid && !prev_vld) begin
        len       = 1;
        abort_len = 0;
        if (sbq.size() == 0) begin
          check("unexpected_strobe", out, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("strobe_value", out, e.oh);
          check("strobe_latency", cyc, e.start);
          check("strobe_count", event_count, e.cnt);
        end
      end else if (out_valid) begin
        len++;
      end else if (prev_vld) begin
        if (!abort_len) check("strobe_length", len, H0);
        abort_len = 0;
      end
      prev_vld = out_valid;
    end
  end

  task automatic send(input logic [1:0] code, input bit keep);
    int base;
    base     = hs_total;
    in_valid = 1'b1;
    in_code  = code;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (hs_total != base) break;
    end
    check("send_handshake_timeout", (hs_total != base), 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_valid = 1'b1;
    in_code  = 2'b11;
    rst      = 1'b1;
    idle(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);

    send(2'b10, 0);
    idle(8);

    send(2'b01, 1);
    send(2'b01, 0);
    idle(8);

    for (int c = 0; c < 4; c++) send(2'(c), 0);
    idle(8);

    // Abort a code-11 strobe on its second cycle while the sender keeps in_valid high.
    send(2'b11, 1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(2'b00, 0);
    idle(8);

    for (int i = 0; i < 300; i++) begin
      bit k;
      k = 1'($urandom_range(0, 1));
      send(2'($urandom_range(0, 3)), k);
      if (!k) idle($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    idle(12);
    check("scoreboard_empty", sbq.size(), 0);
    check("saturated_count", event_count, 255);

    // Second instance: single-cycle strobe and 2-bit saturating counter.
    for (int k = 1; k <= 5; k++) begin
      for (int w = 0; w < 10 && !rdy1; w++) idle(1);
      check("h1_ready", rdy1, 1);
      v1 = 1'b1;
      c1 = 2'(k);
      idle(1);
      v1 = 1'b0;
      check("h1_out", o1, 4'b0001 << c1);
      check("h1_out_valid", ov1, 1);
      check("h1_busy_hold", b1, 1);
      check("h1_count", ec1, (k < 3) ? k : 3);
      idle(1);
      check("h1_gap_out", o1, 0);
      check("h1_gap_busy", b1, 1);
      check("h1_gap_ready", rdy1, 0);
      idle(1);
      check("h1_idle_ready", rdy1, 1);
      check("h1_idle_busy", b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
